// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register sequencer and its datapath.
// Select codes double as command opcodes, so both sides decode the same values.
package usr_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_SETTLE = 2'b10,
        ST_RESP   = 2'b11
    } usr_seq_state_t;

endpackage

// File: rtl/usr_seq.sv
// Command sequencer for a WIDTH-bit universal shift register: runs one
// hold/shift/load command at a time and reports final contents plus exited bits.
module usr_seq
    import usr_pkg::*;
#(
    parameter int  WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [1:0]       usr_select,
    output logic [WIDTH-1:0] usr_d_in,
    output logic             usr_serial_l,
    output logic             usr_serial_r,
    input  logic [WIDTH-1:0] usr_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] rsp_out_bits
);

    usr_seq_state_t   state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] out_bits_q, out_bits_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             accept;
    logic             last_run;
    logic             is_shift;
    logic             cur_data_bit;
    logic             exit_bit;
    logic [CNT_W-1:0] cmd_eff_count;

    // Loads always take one cycle; oversize shift counts clamp at the register width.
    function automatic logic [CNT_W-1:0] eff_count(input logic [1:0] op,
                                                   input logic [CNT_W-1:0] cnt);
        if (op == SEL_LOAD) begin
            return CNT_W'(1);
        end else if (cnt > CNT_W'(WIDTH)) begin
            return CNT_W'(WIDTH);
        end else begin
            return cnt;
        end
    endfunction

    assign accept        = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid;
    assign cmd_eff_count = eff_count(cmd_op, cmd_count);
    assign last_run      = ((idx_q + CNT_W'(1)) == n_q);
    assign is_shift      = (op_q == SEL_SHR) || (op_q == SEL_SHL);
    assign exit_bit      = (op_q == SEL_SHR) ? usr_q[0] : usr_q[WIDTH-1];

    always_comb begin
        cur_data_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx_q == CNT_W'(i)) begin
                cur_data_bit = data_q[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            op_q        <= SEL_HOLD;
            data_q      <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            out_bits_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            op_q        <= op_d;
            data_q      <= data_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            out_bits_q  <= out_bits_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (cmd_eff_count == '0) ? ST_SETTLE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_run) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch, run index, exit-bit capture and response sampling
    always_comb begin
        cmd_ready_d = cmd_ready_q;
        op_d        = op_q;
        data_d      = data_q;
        n_d         = n_q;
        idx_d       = idx_q;
        out_bits_d  = out_bits_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    op_d        = cmd_op;
                    data_d      = cmd_data;
                    n_d         = cmd_eff_count;
                    idx_d       = '0;
                    out_bits_d  = '0;
                end
            end
            ST_RUN: begin
                idx_d = idx_q + CNT_W'(1);
                if (is_shift) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (idx_q == CNT_W'(i)) begin
                            out_bits_d[i] = exit_bit;
                        end
                    end
                end
            end
            ST_SETTLE: rsp_data_d = usr_q;
            ST_RESP: begin
                if (rsp_ready) begin
                    cmd_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        usr_select   = SEL_HOLD;
        usr_d_in     = '0;
        usr_serial_l = 1'b0;
        usr_serial_r = 1'b0;
        if (state_q == ST_RUN) begin
            usr_select = op_q;
            case (op_q)
                SEL_SHR:  usr_serial_l = cur_data_bit;
                SEL_SHL:  usr_serial_r = cur_data_bit;
                SEL_LOAD: usr_d_in     = data_q;
                default: ;
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_data     = rsp_data_q;
    assign rsp_out_bits = out_bits_q;

endmodule

// File: tb/tb_usr_seq.sv
// Self-checking bench for usr_seq driving a behavioural 4-bit universal register,
// with an arithmetic reference model of each command's result and latency.
module tb_usr_seq;
    import usr_pkg::*;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [CW-1:0] cmd_count = '0;
    logic [W-1:0]  cmd_data = '0;
    logic [1:0]    usr_select;
    logic [W-1:0]  usr_d_in;
    logic          usr_serial_l;
    logic          usr_serial_r;
    logic [W-1:0]  usr_q = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic [W-1:0]  rsp_out_bits;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_reg = '0;

    always #5 clk = ~clk;

    usr_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_count    (cmd_count),
        .cmd_data     (cmd_data),
        .usr_select   (usr_select),
        .usr_d_in     (usr_d_in),
        .usr_serial_l (usr_serial_l),
        .usr_serial_r (usr_serial_r),
        .usr_q        (usr_q),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_out_bits (rsp_out_bits)
    );

    // Register datapath; it is not reset, so it keeps its value across a sequencer reset.
    always @(posedge clk) begin
        case (usr_select)
            SEL_SHR:  usr_q <= {usr_serial_l, usr_q[W-1:1]};
            SEL_SHL:  usr_q <= {usr_q[W-2:0], usr_serial_r};
            SEL_LOAD: usr_q <= usr_d_in;
            default:  usr_q <= usr_q;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result register, exited bits and run length from the command rules.
    function automatic void model(input logic [W-1:0] r, input logic [1:0] op, input int cnt,
                                  input logic [W-1:0] d, output logic [W-1:0] nr,
                                  output logic [W-1:0] bits, output int n);
        n    = (op == 2'b11) ? 1 : ((cnt > W) ? W : cnt);
        bits = '0;
        nr   = r;
        if (op == 2'b11) begin
            nr = d;
        end else if (op == 2'b01) begin
            for (int i = 0; i < n; i++) begin
                bits[i] = nr[0];
                nr = (nr >> 1) | (W'(d[i]) << (W - 1));
            end
        end else if (op == 2'b10) begin
            for (int i = 0; i < n; i++) begin
                bits[i] = nr[W-1];
                nr = (nr << 1) | W'(d[i]);
            end
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
        chk({tag, "_select"},    32'(usr_select), 0);
        chk({tag, "_d_in"},      32'(usr_d_in), 0);
        chk({tag, "_serial_l"},  32'(usr_serial_l), 0);
        chk({tag, "_serial_r"},  32'(usr_serial_r), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_data"},  32'(rsp_data), 0);
        chk({tag, "_rsp_bits"},  32'(rsp_out_bits), 0);
    endtask

    // Issue one command, check run-time outputs, latency, response and handshake.
    task automatic do_cmd(input logic [1:0] op, input int cnt, input logic [W-1:0] data,
                          input int ready_delay);
        logic [W-1:0] er;
        logic [W-1:0] eb;
        int n;
        int lat;
        model(exp_reg, op, cnt, data, er, eb, n);
        lat = 0;
        while (!cmd_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = CW'(cnt);
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = ~data;
        chk("ready_drop", 32'(cmd_ready), 0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            chk("run_select", 32'(usr_select), (lat < n) ? 32'(op) : 0);
            chk("run_serial_l", 32'(usr_serial_l),
                (lat < n && op == 2'b01) ? 32'(data[lat]) : 0);
            chk("run_serial_r", 32'(usr_serial_r),
                (lat < n && op == 2'b10) ? 32'(data[lat]) : 0);
            chk("run_d_in", 32'(usr_d_in), (lat < n && op == 2'b11) ? 32'(data) : 0);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, n + 1);
        chk("rsp_data", 32'(rsp_data), 32'(er));
        chk("rsp_bits", 32'(rsp_out_bits), 32'(eb));
        for (int k = 0; k < ready_delay; k++) begin
            cmd_valid = ~cmd_valid;
            cmd_op    = 2'b11;
            cmd_count = CW'(1);
            cmd_data  = ~er;
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_data", 32'(rsp_data), 32'(er));
            chk("bp_bits", 32'(rsp_out_bits), 32'(eb));
            chk("bp_cmd_ready", 32'(cmd_ready), 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hs_valid_low", 32'(rsp_valid), 0);
        chk("hs_cmd_ready", 32'(cmd_ready), 1);
        exp_reg = er;
        $display("cmd op=%0d count=%0d data=%h -> rsp_data=%h bits=%h latency=%0d",
                 op, cnt, data, rsp_data, rsp_out_bits, lat);
    endtask

    initial begin
        // Reset held for 3 cycles
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        rst_n = 1'b1;
        #1;
        chk("release_ready_low", 32'(cmd_ready), 0);
        @(negedge clk);
        chk("release_ready_high", 32'(cmd_ready), 1);

        // Directed scenarios
        do_cmd(2'b11, 0, 4'hA, 0);
        do_cmd(2'b01, 2, 4'b0011, 0);
        do_cmd(2'b10, 7, 4'b0000, 0);
        chk("sat_reg", 32'(usr_q), 0);
        do_cmd(2'b11, 0, 4'h9, 5);
        do_cmd(2'b01, 1, 4'b0001, 0);
        do_cmd(2'b00, 3, 4'hF, 0);
        do_cmd(2'b10, 0, 4'hF, 0);

        // Reset on the second RUN cycle of a count-4 shift
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_count = CW'(4);
        cmd_data  = 4'b1011;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_run_select", 32'(usr_select), 32'(SEL_SHR));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(cmd_ready), 1);
        do_cmd(2'b11, 0, 4'h5, 0);

        // Randomized commands
        for (int t = 0; t < 40; t++) begin
            do_cmd(2'($urandom_range(3)), int'($urandom_range(7)),
                   4'($urandom), int'($urandom_range(3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
